// File: rtl/systolic_result_drain.sv
// ----------------------------------------------------------------------------
// systolic_result_drain
//
// Result collector at the output end of the systolic multiplier. Rows arrive
// one per handshake until a full ARRAY_ROWS x ARRAY_COLUMNS frame is held. The
// frame is then exposed two ways: as a flat row-major vector (mul_outcome) and
// as a word-serial valid/ready stream (out_*) for downstream NTT logic.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer must hold its data stable
// while valid is high and ready is low; valid must not depend on ready. Here
// in_ready and out_valid are decoded from registered state only, so neither
// depends combinationally on any input.
//
// Ports:
//   clk          single clock, rising-edge
//   srst         synchronous active-high reset (overrides flush)
//   in_valid     in_row holds a valid array row
//   in_row       row data, column j at [j*DATA_WIDTH +: DATA_WIDTH]
//   in_ready     high in FILL: a row is accepted this cycle if in_valid
//   flush        abort the current frame, return to FILL (buffer retained)
//   out_valid    high in DRAIN: out_data holds a valid word
//   out_data     current result word, row-major order
//   out_last     marks the final word of the frame
//   out_ready    downstream accepts out_data
//   mul_outcome  frame buffer, element (i,j) at
//                [(i*ARRAY_COLUMNS+j)*DATA_WIDTH +: DATA_WIDTH]
//   frame_valid  mul_outcome holds a complete, stable frame (high in DRAIN)
//   frame_done   one-cycle pulse after the last word is accepted
//   dbg_state    current FSM state (0 = FILL, 1 = DRAIN)
// ----------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int ARRAY_ROWS    = 10,
  parameter int ARRAY_COLUMNS = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                        clk,
  input  logic                                        srst,
  input  logic                                        in_valid,
  input  logic [ARRAY_COLUMNS*DATA_WIDTH-1:0]         in_row,
  output logic                                        in_ready,
  input  logic                                        flush,
  output logic                                        out_valid,
  output logic [DATA_WIDTH-1:0]                       out_data,
  output logic                                        out_last,
  input  logic                                        out_ready,
  output logic [ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH-1:0] mul_outcome,
  output logic                                        frame_valid,
  output logic                                        frame_done,
  output logic                                        dbg_state
);

  localparam int NUM_WORDS = ARRAY_ROWS * ARRAY_COLUMNS;
  localparam int ROW_BITS  = ARRAY_COLUMNS * DATA_WIDTH;
  localparam int ROW_W     = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ARRAY_ROWS - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                        state;
  logic [ROW_W-1:0]              row_cnt;
  logic [WORD_W-1:0]             word_cnt;
  logic [NUM_WORDS*DATA_WIDTH-1:0] frame_q;
  logic                          frame_done_q;

  // ---------------------------------------------------------------------------
  // Single FSM: state, counters, frame buffer and the frame_done pulse.
  // Priority: srst > flush > row/word accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= FILL;
      row_cnt      <= '0;
      word_cnt     <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (flush) begin
        // Any row or word presented alongside flush is dropped; the buffer
        // keeps whatever it held.
        state    <= FILL;
        row_cnt  <= '0;
        word_cnt <= '0;
      end else begin
        case (state)
          FILL: begin
            if (in_valid) begin
              frame_q[int'(row_cnt)*ROW_BITS +: ROW_BITS] <= in_row;
              if (row_cnt == ROW_LAST) begin
                state    <= DRAIN;
                row_cnt  <= '0;
                word_cnt <= '0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (word_cnt == WORD_LAST) begin
                state        <= FILL;
                word_cnt     <= '0;
                frame_done_q <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= FILL;
            row_cnt  <= '0;
            word_cnt <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state/counters only.
  // ---------------------------------------------------------------------------
  assign in_ready    = (state == FILL);
  assign out_valid   = (state == DRAIN);
  assign frame_valid = (state == DRAIN);
  assign out_last    = (state == DRAIN) && (word_cnt == WORD_LAST);
  // Gated so the stream shows zero outside DRAIN rather than a stale word.
  assign out_data    = (state == DRAIN) ?
                       frame_q[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH] :
                       '0;
  assign mul_outcome = frame_q;
  assign frame_done  = frame_done_q;
  assign dbg_state   = state;

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result collector at the output end of the systolic multiplier. It accepts the array's output one row per handshake, `ARRAY_COLUMNS` words wide, until it holds a full `ARRAY_ROWS x ARRAY_COLUMNS` frame. It then exposes the frame two ways: as a flat row-major vector, and as a word-serial valid/ready stream to downstream NTT logic. It sits between `systolic_new` (`out_array` side) and the result memory/writeback path.

## Interface
Parameters:
- `ARRAY_ROWS`, 10, rows per frame (must be ≥ 1).
- `ARRAY_COLUMNS`, 10, words per input row (must be ≥ 1).
- `DATA_WIDTH`, 32, bits per word.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `srst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  `in_row` holds a valid array row.
- `in_row`  in  `ARRAY_COLUMNS*DATA_WIDTH`  row data; column j sits at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`  out  1  block accepts a row this cycle.
- `flush`  in  1  abort the current frame and return to FILL.
- `out_valid`  out  1  `out_data` holds a valid result word.
- `out_data`  out  `DATA_WIDTH`  result word, row-major order.
- `out_last`  out  1  qualifies the final word of a frame (index `ARRAY_ROWS*ARRAY_COLUMNS-1`).
- `out_ready`  in  1  downstream accepts `out_data`.
- `mul_outcome`  out  `ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH`  frame buffer; element (i,j) at `[(i*ARRAY_COLUMNS+j)*DATA_WIDTH +: DATA_WIDTH]`.
- `frame_valid`  out  1  `mul_outcome` holds a complete, stable frame (high throughout DRAIN).
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is accepted.

## Operation
- State machine with two states.
  - FILL: `in_ready`=1. Holds `row_cnt` in 0..`ARRAY_ROWS-1`.
  - DRAIN: `in_ready`=0. Holds `word_cnt` in 0..`ARRAY_ROWS*ARRAY_COLUMNS-1`.
- Row accept: `in_valid && in_ready` writes `in_row` into buffer row `row_cnt` and increments `row_cnt`.
  - On the accept with `row_cnt==ARRAY_ROWS-1`: go to DRAIN, clear `row_cnt` and `word_cnt`.
- DRAIN outputs:
  - `out_valid`=1.
  - `out_data` = buffer word `word_cnt`.
  - `out_last` = (`word_cnt==ARRAY_ROWS*ARRAY_COLUMNS-1`).
- Word accept: `out_valid && out_ready` increments `word_cnt`.
  - On the accept with `out_last`=1: pulse `frame_done` next cycle, go to FILL, clear `word_cnt`.
- Words are passed through unmodified; there is no arithmetic on the data. The counter widths are `$clog2` of their range, minimum 1 bit.
- The buffer is not cleared between frames. Each row is overwritten when the next frame refills it.
- `flush` in any state: go to FILL, clear both counters, force `frame_valid`=0. Buffer contents are retained.
- Simultaneous events:
  - `srst` overrides `flush`.
  - `flush` overrides row accept and word accept in the same cycle; that row or word is dropped and no `frame_done` fires.
- Reset (any cycle, including mid-FILL or mid-DRAIN):
  - state=FILL, `row_cnt`=`word_cnt`=0, buffer cleared to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_last`=0, `frame_valid`=0, `frame_done`=0, `out_data`=0, `mul_outcome`=0.

## Timing
- All outputs are driven from registers or decoded from registered state/counters. There are no combinational paths from inputs to outputs.
- Latency:
  - Final row accepted at edge N → `out_valid`/`frame_valid` high in the cycle after N.
  - The first word is presentable then; with `out_ready` held high, the frame drains in `ARRAY_ROWS*ARRAY_COLUMNS` cycles.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- Turnaround:
  - Last word accepted at edge M → `in_ready`=1 and `frame_done`=1 in cycle M+1.
  - A new row can be accepted at edge M+1.
- Peak throughput: one row per cycle in FILL, one word per cycle in DRAIN.
- The upstream array must hold rows until `in_ready`; rows presented during DRAIN are not accepted.

## Test plan
- Basic frame (2x2, W=32):
  - Stimulus: rows {6,5} then {8,7} (column 0 in the low word).
  - Response: `mul_outcome` words 0..3 = 5,6,7,8; `out_data` sequence 5,6,7,8 with `out_last` only on 8; `frame_done` pulse one cycle after the 8 is accepted.
- Backpressure:
  - Stimulus: drop `out_ready` for 3 cycles while word 2 (value 7) is presented.
  - Response: `out_data`=7 stable and `out_valid`=1 throughout; the sequence completes unchanged.
- Input stall and DRAIN blocking:
  - Stimulus: gap `in_valid` for 2 cycles between rows; present a row during DRAIN.
  - Response: the frame still assembles correctly; the DRAIN-time row is not accepted (`in_ready`=0) and appears nowhere in the output.
- Back-to-back frames:
  - Stimulus: second frame {2,1},{4,3} with `in_valid` held high.
  - Response: first row accepted at the cycle after `frame_done`; output 1,2,3,4.
- Flush:
  - Stimulus: assert `flush` after 1 of 2 rows in FILL; separately, assert `flush` mid-DRAIN together with `out_ready`.
  - Response: FILL case, `row_cnt` returns to 0 and the next 2 rows form the frame. DRAIN case, the word is dropped, `frame_valid`/`out_valid` drop next cycle, and no `frame_done` fires.
- Reset mid-DRAIN:
  - Stimulus: assert `srst` for 1 cycle during DRAIN.
  - Response: the next cycle shows `out_valid`=0, `in_ready`=1, `mul_outcome`=0; a full new frame drains correctly afterwards.
